// File: rtl/fifo_pkg.sv
// Shared types for the FIFO burst reader: FSM state encoding and output entry layout.
package fifo_pkg;

  localparam int unsigned ENTRY_DWIDTH = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    FLUSH = 2'd2
  } burst_rd_state_t;

  typedef struct packed {
    logic [ENTRY_DWIDTH-1:0] data;
    logic                    last;
  } burst_entry_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry output buffer: push from the FIFO side, retire on downstream handshake.
module stream_skid_buf #(
  parameter int unsigned WIDTH = 33
) (
  input  logic             clk_i,
  input  logic             arst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [1:0]       count_o,
  output logic [WIDTH-1:0] head_o
);

  logic [WIDTH-1:0] e0_q, e0_d;
  logic [WIDTH-1:0] e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             do_pop;
  logic             do_push;
  logic [1:0]       cnt_after_pop;

  // Next entries/count: retire shifts entry 1 to the head, push fills the first free slot.
  always_comb begin
    e0_d          = e0_q;
    e1_d          = e1_q;
    do_pop        = pop_i && (cnt_q != 2'd0);
    do_push       = push_i && ((cnt_q != 2'd2) || do_pop);
    cnt_after_pop = cnt_q - 2'(do_pop);
    if (do_pop) begin
      e0_d = e1_q;
    end
    if (do_push) begin
      if (cnt_after_pop == 2'd0) begin
        e0_d = push_data_i;
      end else begin
        e1_d = push_data_i;
      end
    end
    cnt_d = cnt_after_pop + 2'(do_push);
  end

  // Entry and count registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      e0_q  <= '0;
      e1_q  <= '0;
      cnt_q <= 2'd0;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;
  assign head_o  = e0_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Drains a show-ahead FIFO into a valid/ready stream grouped into bursts with last_o.
// Optional partial-burst timeout flush: define FIFO_BURST_READER_TIMEOUT_EN.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH    = 32,
  parameter int unsigned AWIDTH    = 4,
  parameter int unsigned BURST_LEN = 8,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic [DWIDTH-1:0] fifo_q_i,
  input  logic              fifo_empty_i,
  input  logic [AWIDTH:0]   fifo_usedw_i,
  output logic              fifo_rdreq_o,
  output logic [DWIDTH-1:0] data_o,
  output logic              valid_o,
  output logic              last_o,
  input  logic              ready_i,
  output logic              busy_o
);

  localparam int unsigned CWIDTH = AWIDTH + 1;
  localparam int unsigned EWIDTH = DWIDTH + 1;
  localparam logic [CWIDTH-1:0] BURST_LEN_C = CWIDTH'(BURST_LEN);

  if (BURST_LEN == 0 || BURST_LEN > (1 << AWIDTH) || TIMEOUT == 0) begin : g_param_check
    $error("fifo_burst_reader: illegal BURST_LEN/TIMEOUT");
  end

  burst_rd_state_t   state_q, state_d;
  logic [CWIDTH-1:0] words_left_q, words_left_d;
  logic              busy_q, busy_d;
  logic              pop_c;
  logic [1:0]        buf_cnt;
  logic [EWIDTH-1:0] buf_head;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  localparam int unsigned TWIDTH = $clog2(TIMEOUT + 1);
  localparam logic [TWIDTH-1:0] TIMEOUT_C = TWIDTH'(TIMEOUT);
  logic [TWIDTH-1:0] timer_q, timer_d;
`endif

  // Pop only with room in the output buffer; never depends on ready_i.
  always_comb begin
    pop_c = (state_q != IDLE) && (words_left_q != '0) && !fifo_empty_i && (buf_cnt < 2'd2);
  end

  // Next-state, burst word counter and idle timer.
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    timer_d      = '0;
`endif
    case (state_q)
      IDLE: begin
        if (fifo_usedw_i >= BURST_LEN_C) begin
          state_d      = BURST;
          words_left_d = BURST_LEN_C;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        end else if ((timer_q == TIMEOUT_C) && (fifo_usedw_i != '0)) begin
          state_d      = FLUSH;
          words_left_d = fifo_usedw_i;
        end else if (!fifo_empty_i) begin
          timer_d = (timer_q == TIMEOUT_C) ? timer_q : timer_q + TWIDTH'(1);
`endif
        end
      end
      BURST, FLUSH: begin
        if (pop_c) begin
          words_left_d = words_left_q - CWIDTH'(1);
          if (words_left_q == CWIDTH'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      busy_q       <= busy_d;
    end
  end

`ifdef FIFO_BURST_READER_TIMEOUT_EN
  // Idle timer register.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`endif

  stream_skid_buf #(
    .WIDTH (EWIDTH)
  ) u_skid (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .push_i      (pop_c),
    .push_data_i ({fifo_q_i, (words_left_q == CWIDTH'(1))}),
    .pop_i       (ready_i),
    .count_o     (buf_cnt),
    .head_o      (buf_head)
  );

  assign fifo_rdreq_o = pop_c;
  assign data_o       = buf_head[EWIDTH-1:1];
  assign last_o       = buf_head[0];
  assign valid_o      = (buf_cnt != 2'd0);
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Self-checking bench for fifo_burst_reader with a queue-based FIFO and stream model.
module tb_fifo_burst_reader;
  import fifo_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 4;
  localparam int unsigned BL = 8;
  localparam int unsigned TO = 16;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk_i = 1'b0;
  logic          arst_i;
  logic [DW-1:0] fifo_q_i;
  logic          fifo_empty_i;
  logic [AW:0]   fifo_usedw_i;
  logic          fifo_rdreq_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          last_o;
  logic          ready_i;
  logic          busy_o;

  // FIFO model state
  logic [DW-1:0] fq[$];
  logic [DW-1:0] fq_head = '0;
  logic          fq_empty = 1'b1;
  logic [AW:0]   fq_used = '0;
  logic          force_empty;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          force_last;
  int            pops = 0;

  // Expected stream model
  burst_entry_t  exp_q[$];
  int            grp = 0;

  int checks = 0;
  int errors = 0;
  int beats = 0;
  int lasts = 0;
  int occ = 0;
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  assign fifo_q_i     = fq_head;
  assign fifo_empty_i = fq_empty | force_empty;
  assign fifo_usedw_i = fq_used;

  fifo_burst_reader #(
    .DWIDTH    (DW),
    .AWIDTH    (AW),
    .BURST_LEN (BL),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i        (clk_i),
    .arst_i       (arst_i),
    .fifo_q_i     (fifo_q_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_usedw_i (fifo_usedw_i),
    .fifo_rdreq_o (fifo_rdreq_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .last_o       (last_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Show-ahead FIFO model; each written word also gets its expected burst position.
  always @(posedge clk_i) begin
    burst_entry_t e;
    if (fifo_rdreq_o && fq.size() != 0) begin
      void'(fq.pop_front());
      pops++;
    end
    if (wr_en && fq.size() < DEPTH) begin
      fq.push_back(wr_data);
      e.data = wr_data;
      e.last = force_last || (grp == BL - 1);
      grp    = e.last ? 0 : grp + 1;
      exp_q.push_back(e);
    end
    fq_head  <= (fq.size() != 0) ? fq[0] : '0;
    fq_empty <= (fq.size() == 0);
    fq_used  <= (AW+1)'(fq.size());
  end

  // Compare process: stream order/last, buffer occupancy, pop legality, stall stability.
  always @(negedge clk_i) begin
    burst_entry_t e;
    if (arst_i) begin
      occ        = 0;
      prev_stall = 1'b0;
    end else begin
      chk("pop_legal", {63'd0, fifo_rdreq_o && (occ == 2 || fifo_empty_i)}, 64'd0);
      chk("valid_occ", {63'd0, valid_o}, {63'd0, occ != 0});
      if (prev_stall) begin
        chk("stall_hold", {31'd0, valid_o, data_o}, {31'd0, 1'b1, prev_data});
        chk("stall_last", {63'd0, last_o}, {63'd0, prev_last});
      end
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          chk("beat_unexpected", {32'd0, data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("beat_data", {32'd0, data_o}, {32'd0, e.data});
          chk("beat_last", {63'd0, last_o}, {63'd0, e.last});
        end
        beats++;
        if (last_o) lasts++;
      end
      occ        = occ + (fifo_rdreq_o ? 1 : 0) - ((valid_o && ready_i) ? 1 : 0);
      prev_stall = valid_o && !ready_i;
      prev_data  = data_o;
      prev_last  = last_o;
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic wr_word(input logic [DW-1:0] d, input logic lst);
    wr_en      = 1'b1;
    wr_data    = d;
    force_last = lst;
    step();
    wr_en      = 1'b0;
    force_last = 1'b0;
  endtask

  task automatic drain(input string name, input int max);
    int n = 0;
    ready_i = 1'b1;
    while (!(exp_q.size() == 0 && fq.size() == 0 && !valid_o && !busy_o) && n < max) begin
      step();
      n++;
    end
    chk(name, {63'd0, n >= max}, 64'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rdreq"}, {63'd0, fifo_rdreq_o}, 64'd0);
    chk({tag, "_valid"}, {63'd0, valid_o}, 64'd0);
    chk({tag, "_last"},  {63'd0, last_o}, 64'd0);
    chk({tag, "_busy"},  {63'd0, busy_o}, 64'd0);
    chk({tag, "_data"},  {32'd0, data_o}, 64'd0);
  endtask

  initial begin
    int n;
    int b0;
    int l0;
    int p0;
    int wl;
    burst_entry_t e;
    arst_i      = 1'b0;
    ready_i     = 1'b0;
    wr_en       = 1'b0;
    wr_data     = '0;
    force_last  = 1'b0;
    force_empty = 1'b0;
    #1 arst_i = 1'b1;
    #2;
    chk_outputs_zero("reset");
    #9 arst_i = 1'b0;
    step();

    // Full burst with literal cycle-by-cycle expectations.
    ready_i = 1'b1;
    for (int i = 0; i < 8; i++) wr_word(DW'(i), 1'b0);
    chk("fb_pre_busy", {63'd0, busy_o}, 64'd0);
    step();
    chk("fb_busy", {63'd0, busy_o}, 64'd1);
    chk("fb_first_rdreq", {63'd0, fifo_rdreq_o}, 64'd1);
    chk("fb_valid_lat", {63'd0, valid_o}, 64'd0);
    step();
    for (int k = 0; k < 8; k++) begin
      if (k != 0) step();
      chk("fb_valid", {63'd0, valid_o}, 64'd1);
      chk("fb_data", {32'd0, data_o}, 64'(k));
      chk("fb_last", {63'd0, last_o}, {63'd0, k == 7});
      chk("fb_busy_run", {63'd0, busy_o}, {63'd0, k != 7});
    end
    step();
    chk("fb_done_valid", {63'd0, valid_o}, 64'd0);

    // Back-pressure: 16 words, ready toggles every cycle.
    b0 = beats; l0 = lasts;
    for (int i = 0; i < 16; i++) begin
      ready_i = ~ready_i;
      wr_word(DW'(100 + i), 1'b0);
    end
    n = 0;
    while (!(exp_q.size() == 0 && !valid_o && !busy_o) && n < 200) begin
      ready_i = ~ready_i;
      step();
      n++;
    end
    chk("bp_timeout", {63'd0, n >= 200}, 64'd0);
    chk("bp_beats", 64'(beats - b0), 64'd16);
    chk("bp_lasts", 64'(lasts - l0), 64'd2);

    // Partial data: flushed by the timeout, or left waiting without it.
    ready_i = 1'b1;
    b0 = beats; l0 = lasts;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
    wr_word(32'hA0, 1'b0);
    wr_word(32'hA1, 1'b0);
    wr_word(32'hA2, 1'b1);
    grp = 0;
    n = 0;
    while (lasts == l0 && n < 60) begin
      step();
      n++;
    end
    chk("to_timeout", {63'd0, n >= 60}, 64'd0);
    chk("to_wait_min", {63'd0, n >= TO}, 64'd1);
    chk("to_beats", 64'(beats - b0), 64'd3);
    drain("to_drain", 50);
`else
    wr_word(32'hA0, 1'b0);
    wr_word(32'hA1, 1'b0);
    wr_word(32'hA2, 1'b0);
    n = 0;
    for (int i = 0; i < 1000; i++) begin
      if (valid_o || busy_o) n++;
      step();
    end
    chk("nto_idle", 64'(n), 64'd0);
    chk("nto_beats", 64'(beats - b0), 64'd0);
    for (int i = 0; i < 5; i++) wr_word(DW'(32'hA3 + i), 1'b0);
    drain("nto_drain", 50);
    chk("nto_beats_after", 64'(beats - b0), 64'd8);
    chk("nto_lasts_after", 64'(lasts - l0), 64'd1);
`endif

    // Empty stall in the middle of a burst.
    b0 = beats;
    for (int i = 0; i < 8; i++) wr_word(DW'(200 + i), 1'b0);
    step(); step(); step();
    force_empty = 1'b1;
    p0 = pops;
    for (int i = 0; i < 5; i++) step();
    chk("stall_pops", 64'(pops - p0), 64'd0);
    chk("stall_busy", {63'd0, busy_o}, 64'd1);
    force_empty = 1'b0;
    drain("stall_drain", 50);
    chk("stall_beats", 64'(beats - b0), 64'd8);

    // Asynchronous reset mid-burst with stalled output.
    ready_i = 1'b0;
    b0 = beats; l0 = lasts;
    for (int i = 0; i < 12; i++) wr_word(DW'(300 + i), 1'b0);
    for (int i = 0; i < 4; i++) step();
    #2 arst_i = 1'b1;
    #1;
    chk_outputs_zero("arst");
    exp_q.delete();
    grp = 0;
    for (int i = 0; i < fq.size(); i++) begin
      e.data = fq[i];
      e.last = (grp == BL - 1);
      grp    = e.last ? 0 : grp + 1;
      exp_q.push_back(e);
    end
    chk("arst_fifo_kept", 64'(fq.size()), 64'd10);
    step();
    #2 arst_i = 1'b0;
    step();
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) wr_word(DW'(400 + i), 1'b0);
    drain("arst_drain", 100);
    chk("arst_beats", 64'(beats - b0), 64'd16);
    chk("arst_lasts", 64'(lasts - l0), 64'd2);

    // Randomized traffic: whole groups of BURST_LEN words, random ready.
    b0 = beats;
    wl = 0;
    p0 = 0;
    for (int c = 0; c < 3000; c++) begin
      ready_i = ($urandom_range(0, 3) != 0);
      if (wl == 0 && fq.size() <= DEPTH - BL && $urandom_range(0, 3) == 0) begin
        wl = BL;
        p0 += BL;
      end
      if (wl > 0) begin
        wr_en   = 1'b1;
        wr_data = $urandom;
        wl--;
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    while (wl > 0) begin
      wr_en   = 1'b1;
      wr_data = $urandom;
      wl--;
      step();
    end
    wr_en = 1'b0;
    drain("rnd_drain", 200);
    chk("rnd_beats", 64'(beats - b0), 64'(p0));
    chk("final_exp_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
